alu_share_arbiter: RTL
======================

Name: alu_share_arbiter

Overview:
- Shares one 48-bit DSP ALU instance between NUM_REQ requesters.
- Each requester presents a full operation (X, Y, Z, carry-in, OPMODE, ALUMODE) with a valid/ready handshake.
- Round-robin arbitration picks one request per cycle. Operands are registered, the ALU evaluates them, and the result is returned on a single response channel tagged with the requester ID.
- Sits between the DSP slice's operand muxes and its P-register logic.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- DATA_W, 48, operand/result width; must equal the ALU width
- ID_W, $clog2(NUM_REQ), width of the requester tag

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero
- req_x  in  NUM_REQ*DATA_W  X operands, requester i at slice [i*DATA_W +: DATA_W]
- req_y  in  NUM_REQ*DATA_W  Y operands, same packing
- req_z  in  NUM_REQ*DATA_W  Z operands, same packing
- req_cin  in  NUM_REQ  carry-in per requester
- req_opmode  in  NUM_REQ*7  OPMODE per requester
- req_alumode  in  NUM_REQ*4  ALUMODE per requester
- rsp_valid  out  1  result valid
- rsp_ready  in  1  consumer accepts result
- rsp_id  out  ID_W  index of the requester that owns the result
- rsp_p  out  DATA_W  ALU result P
- rsp_carry  out  1  ALU carry-out
- rsp_err  out  1  unsupported OPMODE/ALUMODE flag (see Optional Feature)

Behaviour:
- Reset (async assert, sync release):
  - all outputs 0
  - round-robin pointer = 0 (requester 0 has highest priority)
  - both pipeline stages empty
- Pipeline has two stages.
  - S1 holds the granted operands plus id and valid.
  - The ALU is combinational on S1.
  - S2 holds P, carry, id, err and valid; S2 drives the rsp_* outputs directly.
- Latency: a request accepted at edge E0 appears on rsp_* after edge E1. That is a 1-cycle gap, with rsp_valid high in the cycle after S1 loads.
- Throughput: one operation per cycle when rsp_ready is held high.
- Stall rule:
  - S2 advances when !rsp_valid or rsp_ready.
  - S1 advances when S2 advances or S1 is empty.
  - req_ready may be asserted only when S1 advances.
- Arbitration:
  - Among asserted req_valid, grant the first index at or after the pointer, wrapping modulo NUM_REQ.
  - req_ready[grant] = 1 only when S1 advances. Otherwise all req_ready = 0.
  - On a handshake, pointer = grant+1, wrapping from NUM_REQ-1 to 0. With no handshake the pointer holds.
- No request is dropped or reordered. Responses leave in acceptance order.
- rsp_* stay stable while rsp_valid && !rsp_ready.
- Requester inputs are sampled only on its handshake edge; changes at other times are ignored.
- A requester may hold req_valid across consecutive grants. Round-robin order still interleaves the other active requesters.
- ALU arithmetic follows the DSP ALUMODE semantics:
  - 0000 Z+X+Y+CIN
  - 0011 Z-(X+Y+CIN)
  - 01xx/11xx logic ops, selected by OPMODE[3:2]
  - carry is bit 48 of the arithmetic sum
  - unsupported codes yield P=0, carry=0
- Reset asserted mid-operation: both stages are cleared immediately and in-flight operations are lost. rsp_valid drops asynchronously.

Optional Feature:
- Macro ALU_MODE_CHECK_EN.
- Defined: S1 decodes {OPMODE[3:2], ALUMODE}. rsp_err=1 when any of these holds:
  - ALUMODE is 10xx
  - ALUMODE is 01xx or 11xx and OPMODE[3:2] is 01 or 11
- rsp_err travels with its result through S2.
- Not defined: rsp_err tied to 0 and no decode logic is built.

Decomposition:
- Package alu_ctrl_pkg:
  - ALUMODE localparams: ALU_ADD=4'b0000, ALU_SUB=4'b0011, ALU_XOR=4'b0100, ALU_AND=4'b1100
  - DATA_W default
  - helper function for the mode-legality check
- Sub-module rr_arbiter: NUM_REQ-wide round-robin grant with pointer register, inputs req and advance, output one-hot grant.
- The existing ALU is instantiated unmodified.

Test Plan:
- Single add: requester 0 sends X=5, Y=3, Z=0, CIN=0, ALUMODE=0000 -> rsp_p=8, carry=0, id=0 one cycle after the handshake.
- Carry: X=48'hFFFF_FFFF_FFFF, Y=1, Z=0 -> rsp_p=0, rsp_carry=1.
- Fairness: requesters 0..3 all valid for 8 cycles with rsp_ready=1 -> grant order 0,1,2,3,0,1,2,3, one per cycle.
- Backpressure: hold rsp_ready=0 for 3 cycles with two requests queued -> rsp_* frozen, req_ready=0 after both stages fill, no loss, results in order after release.
- Reset mid-stream: pull rst_n low with S1 and S2 full -> rsp_valid=0 immediately; after release, pointer=0 and requester 0 is granted first.
- With ALU_MODE_CHECK_EN: ALUMODE=1000 -> rsp_err=1 and rsp_p=0. Same request without the macro -> rsp_err=0 and rsp_p=0.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// Shared control definitions for the shared DSP ALU: ALUMODE codes, the
// default datapath width and the OPMODE/ALUMODE legality check.
package alu_ctrl_pkg;

  localparam int DATA_W = 48;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0011;
  localparam logic [3:0] ALU_XOR = 4'b0100;
  localparam logic [3:0] ALU_AND = 4'b1100;

  // Flags combinations the ALU cannot execute: the 10xx ALUMODE family, and
  // logic ALUMODEs whose operand selection OPMODE[3:2] is 01 or 11.
  function automatic logic mode_illegal(input logic [1:0] opsel,
                                        input logic [3:0] alumode);
    return (alumode[3:2] == 2'b10) || (alumode[2] && opsel[0]);
  endfunction

endpackage

// File: rtl/dsp_alu.sv
// Combinational 48-bit DSP ALU. Arithmetic uses ALUMODE 0000/0011, logic ops
// use ALUMODE 01xx/11xx with OPMODE[3:2] choosing the logic variant.
// Unsupported codes return P=0 and carry=0.
module dsp_alu
  import alu_ctrl_pkg::*;
#(
  parameter int W = 48
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic [W-1:0] z,
  input  logic         cin,
  input  logic [6:0]   opmode,
  input  logic [3:0]   alumode,
  output logic [W-1:0] p,
  output logic         carry_out
);

  logic [W:0] xy_sum;
  logic [W:0] add_res;
  logic [W:0] sub_res;
  logic [1:0] opsel;
  logic       unused_opmode_bits;

  // Only OPMODE[3:2] influences the ALU; the other bits steer the operand muxes.
  assign opsel              = opmode[3:2];
  assign unused_opmode_bits = ^{opmode[6:4], opmode[1:0]};

  // Arithmetic and logic result selection; carry is bit W of the arithmetic result.
  always_comb begin
    xy_sum    = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, cin};
    add_res   = {1'b0, z} + xy_sum;
    sub_res   = {1'b0, z} - xy_sum;
    p         = '0;
    carry_out = 1'b0;
    case (alumode)
      ALU_ADD: begin
        p         = add_res[W-1:0];
        carry_out = add_res[W];
      end
      ALU_SUB: begin
        p         = sub_res[W-1:0];
        carry_out = sub_res[W];
      end
      default: begin
        if (alumode[2] && opsel == 2'b00) begin
          case (alumode)
            4'b0100, 4'b0111: p = x ^ z;
            4'b0101, 4'b0110: p = ~(x ^ z);
            4'b1100:          p = x & z;
            4'b1101:          p = x & ~z;
            4'b1110:          p = ~(x & z);
            4'b1111:          p = ~x | z;
            default:          p = '0;
          endcase
        end else if (alumode[2] && opsel == 2'b10) begin
          case (alumode)
            4'b0100, 4'b0111: p = ~(x ^ z);
            4'b0101, 4'b0110: p = x ^ z;
            4'b1100:          p = x | z;
            4'b1101:          p = x | ~z;
            4'b1110:          p = ~(x | z);
            4'b1111:          p = ~x & z;
            default:          p = '0;
          endcase
        end
      end
    endcase
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first asserted request at or after the
// pointer (wrapping), and moves the pointer past the winner when advance is
// high and something was granted.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx
);

  logic [ID_W-1:0] ptr_q, ptr_d;
  logic            found;
  int              pos;
  logic [ID_W-1:0] idx;

  // Rotating priority scan starting at the pointer.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    pos       = 0;
    idx       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      pos = (int'(ptr_q) + i) % NUM_REQ;
      idx = ID_W'(pos);
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

  // Pointer moves to the slot after the winner only on an accepted grant.
  always_comb begin
    ptr_d = ptr_q;
    if (advance && found) begin
      ptr_d = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
    end
  end

  // Pointer register; requester 0 has top priority out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one DSP ALU between NUM_REQ requesters. Round-robin grant into S1
// (registered operands), combinational ALU on S1, results registered in S2
// which drives the response channel.
// Optional macro ALU_MODE_CHECK_EN: builds the OPMODE/ALUMODE legality decode
// that drives rsp_err; without it rsp_err is constant 0.
//
// Handshakes: a transfer happens on a rising edge where valid && ready.
// req_ready is one-hot (or zero) and only asserted when S1 can load; valid
// must not depend on ready; rsp_* hold steady while rsp_valid && !rsp_ready.
module alu_share_arbiter
  import alu_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = alu_ctrl_pkg::DATA_W,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_x,
  input  logic [NUM_REQ*DATA_W-1:0] req_y,
  input  logic [NUM_REQ*DATA_W-1:0] req_z,
  input  logic [NUM_REQ-1:0]        req_cin,
  input  logic [NUM_REQ*7-1:0]      req_opmode,
  input  logic [NUM_REQ*4-1:0]      req_alumode,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [ID_W-1:0]           rsp_id,
  output logic [DATA_W-1:0]         rsp_p,
  output logic                      rsp_carry,
  output logic                      rsp_err
);

  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_idx;
  logic               s1_adv, s2_adv, hs;

  logic              s1_valid_q,   s1_valid_d;
  logic [DATA_W-1:0] s1_x_q,       s1_x_d;
  logic [DATA_W-1:0] s1_y_q,       s1_y_d;
  logic [DATA_W-1:0] s1_z_q,       s1_z_d;
  logic              s1_cin_q,     s1_cin_d;
  logic [6:0]        s1_opmode_q,  s1_opmode_d;
  logic [3:0]        s1_alumode_q, s1_alumode_d;
  logic [ID_W-1:0]   s1_id_q,      s1_id_d;

  logic              s2_valid_q, s2_valid_d;
  logic [DATA_W-1:0] s2_p_q,     s2_p_d;
  logic              s2_carry_q, s2_carry_d;
  logic [ID_W-1:0]   s2_id_q,    s2_id_d;
  logic              s2_err_q,   s2_err_d;

  logic [DATA_W-1:0] alu_p;
  logic              alu_carry;
  logic              s1_err;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req_valid),
    .advance   (s1_adv),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // Stall chain: S2 drains when the consumer takes it, S1 moves when S2 moves.
  always_comb begin
    s2_adv    = !s2_valid_q || rsp_ready;
    s1_adv    = s2_adv || !s1_valid_q;
    req_ready = s1_adv ? grant : '0;
    hs        = |req_ready;
  end

  // S1 loads the granted requester's operands; holds while stalled.
  always_comb begin
    s1_valid_d   = s1_valid_q;
    s1_x_d       = s1_x_q;
    s1_y_d       = s1_y_q;
    s1_z_d       = s1_z_q;
    s1_cin_d     = s1_cin_q;
    s1_opmode_d  = s1_opmode_q;
    s1_alumode_d = s1_alumode_q;
    s1_id_d      = s1_id_q;
    if (s1_adv) begin
      s1_valid_d = hs;
      if (hs) begin
        s1_x_d       = req_x[32'(grant_idx) * DATA_W +: DATA_W];
        s1_y_d       = req_y[32'(grant_idx) * DATA_W +: DATA_W];
        s1_z_d       = req_z[32'(grant_idx) * DATA_W +: DATA_W];
        s1_cin_d     = req_cin[grant_idx];
        s1_opmode_d  = req_opmode[32'(grant_idx) * 7 +: 7];
        s1_alumode_d = req_alumode[32'(grant_idx) * 4 +: 4];
        s1_id_d      = grant_idx;
      end
    end
  end

  // S1 register bank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_x_q       <= '0;
      s1_y_q       <= '0;
      s1_z_q       <= '0;
      s1_cin_q     <= 1'b0;
      s1_opmode_q  <= '0;
      s1_alumode_q <= '0;
      s1_id_q      <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_x_q       <= s1_x_d;
      s1_y_q       <= s1_y_d;
      s1_z_q       <= s1_z_d;
      s1_cin_q     <= s1_cin_d;
      s1_opmode_q  <= s1_opmode_d;
      s1_alumode_q <= s1_alumode_d;
      s1_id_q      <= s1_id_d;
    end
  end

  dsp_alu #(
    .W (DATA_W)
  ) u_alu (
    .x         (s1_x_q),
    .y         (s1_y_q),
    .z         (s1_z_q),
    .cin       (s1_cin_q),
    .opmode    (s1_opmode_q),
    .alumode   (s1_alumode_q),
    .p         (alu_p),
    .carry_out (alu_carry)
  );

`ifdef ALU_MODE_CHECK_EN
  // Legality decode of the operation sitting in S1.
  always_comb begin
    s1_err = mode_illegal(s1_opmode_q[3:2], s1_alumode_q);
  end
`else
  assign s1_err = 1'b0;
`endif

  // S2 captures the ALU result of a valid S1 entry when it may advance.
  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_p_d     = s2_p_q;
    s2_carry_d = s2_carry_q;
    s2_id_d    = s2_id_q;
    s2_err_d   = s2_err_q;
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_p_d     = alu_p;
        s2_carry_d = alu_carry;
        s2_id_d    = s1_id_q;
        s2_err_d   = s1_err;
      end
    end
  end

  // S2 register bank; reset clears the response outputs asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      s2_p_q     <= '0;
      s2_carry_q <= 1'b0;
      s2_id_q    <= '0;
      s2_err_q   <= 1'b0;
    end else begin
      s2_valid_q <= s2_valid_d;
      s2_p_q     <= s2_p_d;
      s2_carry_q <= s2_carry_d;
      s2_id_q    <= s2_id_d;
      s2_err_q   <= s2_err_d;
    end
  end

  assign rsp_valid = s2_valid_q;
  assign rsp_p     = s2_p_q;
  assign rsp_carry = s2_carry_q;
  assign rsp_id    = s2_id_q;
  assign rsp_err   = s2_err_q;

endmodule
